// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for a filtered clock lock, holds downstream reset for a fixed
// time, then releases it; re-enters the sequence on lock loss or software reset.
module reset_sequencer #(
   parameter int unsigned LOCK_FILTER = 16,
   parameter int unsigned HOLD_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       locked,
   input  logic       soft_reset,
   output logic       resetn_out,
   output logic       ready,
   output logic [1:0] state,
   output logic [7:0] reset_count
);

   typedef enum logic [1:0] {
      StRst      = 2'b00,
      StWaitLock = 2'b01,
      StHold     = 2'b10,
      StRun      = 2'b11
   } state_e;

   localparam logic [15:0] FilterLast = 16'(LOCK_FILTER - 1);
   localparam logic [15:0] HoldLast   = 16'(HOLD_CYCLES - 1);

   logic [1:0]  rst_sync_q;
   logic [1:0]  lock_sync_q;
   logic        locked_s;
   state_e      state_q;
   logic [15:0] filter_q;
   logic [15:0] hold_q;

   // Internal reset asserts with resetn, releases two edges after resetn rises.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_sync_q <= 2'b00;
      end else begin
         lock_sync_q <= {lock_sync_q[0], locked};
      end
   end

   assign locked_s = lock_sync_q[1];

   // resetn_out/ready are updated on every transition into or out of RUN.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StRst;
         filter_q    <= '0;
         hold_q      <= '0;
         resetn_out  <= 1'b0;
         ready       <= 1'b0;
         reset_count <= '0;
      end else begin
         case (state_q)
            StRst: begin
               if (rst_sync_q[1]) begin
                  state_q  <= StWaitLock;
                  filter_q <= '0;
               end
            end
            StWaitLock: begin
               if (!locked_s) begin
                  filter_q <= '0;
               end else if (filter_q == FilterLast) begin
                  state_q <= StHold;
                  hold_q  <= '0;
               end else begin
                  filter_q <= filter_q + 16'd1;
               end
            end
            StHold: begin
               if (!locked_s) begin
                  state_q  <= StWaitLock;
                  filter_q <= '0;
               end else if (soft_reset) begin
                  hold_q <= '0;
               end else if (hold_q == HoldLast) begin
                  state_q    <= StRun;
                  resetn_out <= 1'b1;
                  ready      <= 1'b1;
               end else begin
                  hold_q <= hold_q + 16'd1;
               end
            end
            StRun: begin
               if (!locked_s || soft_reset) begin
                  resetn_out <= 1'b0;
                  ready      <= 1'b0;
                  if (reset_count != 8'hff) begin
                     reset_count <= reset_count + 8'd1;
                  end
                  // Lock loss wins over a simultaneous soft reset.
                  if (!locked_s) begin
                     state_q  <= StWaitLock;
                     filter_q <= '0;
                  end else begin
                     state_q <= StHold;
                     hold_q  <= '0;
                  end
               end
            end
            default: begin
               state_q <= StRst;
            end
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer against a cycle-level behavioural model.
module tb_reset_sequencer;

   localparam int LF = 4;
   localparam int HC = 8;

   logic       clk;
   logic       resetn;
   logic       locked;
   logic       soft_reset;
   logic       resetn_out;
   logic       ready;
   logic [1:0] state;
   logic [7:0] reset_count;

   reset_sequencer #(
      .LOCK_FILTER(LF),
      .HOLD_CYCLES(HC)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .locked     (locked),
      .soft_reset (soft_reset),
      .resetn_out (resetn_out),
      .ready      (ready),
      .state      (state),
      .reset_count(reset_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: spec-level state code, counters, lock history and edges since resetn rose.
   int m_st;
   int m_filt;
   int m_hold;
   int m_cnt;
   int m_edges;
   bit m_hist[$];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_st = 0; m_filt = 0; m_hold = 0; m_cnt = 0; m_edges = 0;
      m_hist = '{0, 0};
   endtask

   task automatic model_edge();
      bit ls;
      if (!resetn) return;
      ls = m_hist[1];  // locked as sampled two edges ago
      void'(m_hist.pop_back());
      m_hist.push_front(locked);
      if (m_edges < 2) begin
         m_edges++;
         return;
      end
      case (m_st)
         0: begin m_st = 1; m_filt = 0; end
         1: begin
            if (!ls) m_filt = 0;
            else if (m_filt == LF - 1) begin m_st = 2; m_hold = 0; end
            else m_filt++;
         end
         2: begin
            if (!ls) begin m_st = 1; m_filt = 0; end
            else if (soft_reset) m_hold = 0;
            else if (m_hold == HC - 1) m_st = 3;
            else m_hold++;
         end
         default: begin
            if (!ls || soft_reset) begin
               if (m_cnt < 255) m_cnt++;
               if (!ls) begin m_st = 1; m_filt = 0; end
               else begin m_st = 2; m_hold = 0; end
            end
         end
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("state", int'(state), m_st);
      check("resetn_out", int'(resetn_out), int'(m_st == 3));
      check("ready", int'(ready), int'(m_st == 3));
      check("reset_count", int'(reset_count), m_cnt);
   endtask

   // Called 1 time unit after an edge; drops resetn between edges.
   task automatic async_reset();
      #3 resetn = 1'b0;
      #1;
      check("async_state", int'(state), 0);
      check("async_resetn_out", int'(resetn_out), 0);
      check("async_ready", int'(ready), 0);
      check("async_count", int'(reset_count), 0);
      model_reset();
      step();
      step();
      resetn = 1'b1;
   endtask

   task automatic wait_run(input int budget);
      int n = 0;
      while (!ready && n < budget) begin
         step();
         n++;
      end
      check("run_reached", int'(ready), 1);
   endtask

   initial begin
      int first_ready;
      resetn = 1'b0; locked = 1'b1; soft_reset = 1'b0;
      model_reset();
      step();
      step();

      // Release latency with locked stable
      resetn = 1'b1;
      first_ready = 0;
      for (int e = 1; e <= 20; e++) begin
         step();
         if (ready && first_ready == 0) first_ready = e;
      end
      check("release_edge", first_ready, 3 + LF + HC);

      // Lock glitch during WAIT_LOCK at filter=2
      async_reset();
      for (int i = 0; i < 40 && !(m_st == 1 && m_filt == 2); i++) step();
      locked = 1'b0;
      step();
      locked = 1'b1;
      wait_run(40);

      // Lock loss in RUN, then recovery
      locked = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("lockloss_count", int'(reset_count), 1);
      locked = 1'b1;
      wait_run(40);

      // Single soft reset pulse in RUN
      soft_reset = 1'b1;
      step();
      soft_reset = 1'b0;
      check("soft_hold", int'(state), 2);
      wait_run(20);

      // Soft reset coincident with synchronized lock fall
      locked = 1'b0;
      step();
      step();
      soft_reset = 1'b1;
      step();
      soft_reset = 1'b0;
      check("coincident_state", int'(state), 1);
      locked = 1'b1;
      wait_run(40);

      // Saturation
      for (int i = 0; i < 300; i++) begin
         soft_reset = 1'b1;
         step();
         soft_reset = 1'b0;
         wait_run(20);
      end
      check("saturated", int'(reset_count), 255);

      // Async reset mid-HOLD
      soft_reset = 1'b1;
      step();
      soft_reset = 1'b0;
      step();
      step();
      async_reset();

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         if (locked) locked = ($urandom_range(0, 29) != 0);
         else locked = ($urandom_range(0, 3) == 0);
         soft_reset = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 399) == 0) async_reset();
         else step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
